// File: rtl/avr_uart_tx.sv
// avr_uart_tx: 8N1 UART transmitter from the fabric to the AVR (avr_rx pin).
// Takes one byte per tx_valid/tx_ready handshake and sends it LSB-first.
// The AVR busy pin (block) is synchronised and only holds off the next accept.
// An in-flight frame always completes.
// Optional feature: define AVR_UART_TX_PARITY_EN to add an even-parity bit
// between the last data bit and the stop bit.
module avr_uart_tx #(
    parameter int CLK_PER_BIT = 100,
    parameter int CTR_SIZE    = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       block,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef AVR_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    localparam logic [CTR_SIZE-1:0] LAST_CNT = CTR_SIZE'(CLK_PER_BIT - 1);

    state_t              state;
    logic [7:0]          shift;
    logic [2:0]          bit_idx;
    logic [CTR_SIZE-1:0] clk_cnt;
    logic                armed;
    logic                block_meta;
    logic                block_s;
    logic                bit_end;
`ifdef AVR_UART_TX_PARITY_EN
    logic                parity_bit;
`endif

    assign bit_end = (clk_cnt == LAST_CNT);

    // Ready only in IDLE, while the AVR is not blocking, and once reset has been released for a cycle.
    assign tx_ready = armed & (state == IDLE) & ~block_s;

    // Busy while a frame is on the wire, or while the AVR asks us to hold off.
    assign busy = (state != IDLE) | block_s;

    // Two-flop synchroniser for the asynchronous AVR busy pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block_meta <= 1'b0;
            block_s    <= 1'b0;
        end else begin
            block_meta <= block;
            block_s    <= block_meta;
        end
    end

    // Framing state machine.
    // tx is registered here so the serial line never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shift   <= 8'h00;
            bit_idx <= 3'd0;
            clk_cnt <= '0;
            armed   <= 1'b0;
`ifdef AVR_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        shift   <= tx_data;
                        clk_cnt <= '0;
                        bit_idx <= 3'd0;
                        tx      <= 1'b0;
                        state   <= START;
`ifdef AVR_UART_TX_PARITY_EN
                        parity_bit <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CTR_SIZE'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        shift   <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
`ifdef AVR_UART_TX_PARITY_EN
                            tx      <= parity_bit;
                            state   <= PARITY;
`else
                            tx      <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CTR_SIZE'(1);
                    end
                end
`ifdef AVR_UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CTR_SIZE'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + CTR_SIZE'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/avr_uart_tx.md
Name: avr_uart_tx

Overview:
- 8N1 UART transmitter driving the FPGA Tx line toward the AVR (board pin avr_rx), with AVR flow control via the AVR Rx-busy pin (avr_rx_busy).
- Sits between fabric logic (e.g. counter/debouncer status) and the top-level serial pin.
- Accepts one byte per valid/ready handshake and serialises it LSB-first.

Parameters:
- CLK_PER_BIT, 100, clock cycles per bit (50 MHz / 500 kbaud); legal range >= 2.
- CTR_SIZE, 7, width of the bit-period counter; must satisfy 2^CTR_SIZE >= CLK_PER_BIT.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  asynchronous, active-high reset.
- block  input  1  AVR Rx buffer full (connect to avr_rx_busy); asynchronous to clk.
- tx_data  input  8  byte to send; sampled on accept.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  block can accept a byte this cycle.
- busy  output  1  frame in progress, or block asserted.
- tx  output  1  serial line to AVR; idle high.

Behaviour:
- Reset (async, any state, including mid-frame): tx=1, tx_ready=0, busy=0, state=IDLE, counters=0, both block sync flops=0; takes effect immediately, no partial frame completes.
- block passes through a 2-FF synchroniser; block_s = second flop. 2-cycle latency from pin to block_s.
- States: IDLE, START, DATA, [PARITY], STOP.
- IDLE:
  - tx=1.
  - tx_ready = ~block_s (registered-free combinational from state and block_s).
  - busy = block_s.
  - Accept when tx_valid & tx_ready: latch tx_data into shift register, clear counters, go to START.
- START: tx=0 for CLK_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift[0] for CLK_PER_BIT cycles per bit.
  - Shift right after each bit; bit index 0..7.
  - After bit 7, go to STOP (or PARITY if enabled).
- STOP: tx=1 for CLK_PER_BIT cycles, then go to IDLE.
- Outside IDLE: tx_ready=0, busy=1.
- Timing:
  - tx falls on the first clk edge after the accepting edge.
  - Frame = 10*CLK_PER_BIT cycles (11* with parity).
  - IDLE lasts at least 1 cycle between frames: with tx_valid held high, start-to-start spacing = 10*CLK_PER_BIT+1 cycles.
- tx is driven from a register (glitch-free); no combinational path from inputs to tx.
- block is sampled only in IDLE. Assertion mid-frame never aborts or stretches the current frame; it only prevents the next accept.
- block deasserts while tx_valid is high: accept occurs in the first cycle block_s=0.
- tx_data/tx_valid changes when not accepted: ignored; the latched byte is immutable until the frame ends.
- Bit counter wraps only via explicit clear; bit-period counter counts 0..CLK_PER_BIT-1, then clears.

Optional Feature:
- Macro: AVR_UART_TX_PARITY_EN.
- Defined:
  - Adds PARITY state between DATA and STOP.
  - tx = even parity (XOR of the 8 latched bits) for CLK_PER_BIT cycles.
  - Frame = 11*CLK_PER_BIT cycles; back-to-back spacing = 11*CLK_PER_BIT+1.
- Undefined: no PARITY state or parity logic; 8N1 framing as above.

Test Plan:
- CLK_PER_BIT=4, send 0xA5 → tx low 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles. tx_ready low for 40 cycles, returns high on cycle 41.
- block=1 held, tx_valid=1 with 0x3C → tx stays 1, tx_ready=0, busy=1 indefinitely. Release block → frame starts 3 cycles later (2 sync + 1 accept edge).
- tx_valid held high with 0x01 then 0xFF presented on each accept → two frames, start edges 41 cycles apart, correct data in each.
- Assert block during bit 3 of 0x55 → frame completes unaltered. No new accept until block released and synchronised.
- Assert rst during DATA bit 5 → tx=1 and tx_ready=0 in the same cycle. After rst falls, tx_ready=1 next cycle, and a new byte 0x80 transmits correctly.
- AVR_UART_TX_PARITY_EN defined, CLK_PER_BIT=4, send 0x07 → parity bit=1 for 4 cycles after bit 7. Send 0x03 → parity=0. Frame length 44 cycles.
